// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-port arbiter: state encoding,
// beat counter width and the grant index width helper.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam int BEAT_W = 8;

    // Index width for n producers; never less than 1 bit.
    function automatic int arb_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first set request at or above i_rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = arb_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    int unsigned      w_idx;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = 0;
        w_pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(i_rr_ptr) + k) % 32'(NUM_REQ);
            w_pos = IDX_W'(w_idx);
            if (!o_found && i_req[w_pos]) begin
                o_found = 1'b1;
                o_index = w_pos;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready
// producers, with bursts of up to MAX_BURST beats (1 beat under almost_full).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_BURST  = 8,
    localparam int IDX_W      = arb_clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_id,
    output logic [BEAT_W-1:0]             beat_cnt
);

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic              w_found;
    logic [IDX_W-1:0]  w_pick;
    logic              w_burst;
    logic              w_sel_valid;
    logic              w_wr_en;
    logic [BEAT_W-1:0] w_limit;
    logic [BEAT_W:0]   w_beat_inc;
    logic              w_release;
    logic [IDX_W-1:0]  w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_index  (w_pick)
    );

    assign w_burst     = (r_state == ST_BURST);
    assign w_sel_valid = req_valid[r_grant_id];
    assign w_wr_en     = w_burst & w_sel_valid & ~fifo_full;
    assign w_limit     = fifo_almost_full ? BEAT_W'(1) : BEAT_W'(MAX_BURST);
    assign w_beat_inc  = {1'b0, r_beat_cnt} + 1'b1;

    // Release on the beat that reaches the limit, or as soon as the owner drops valid.
    assign w_release   = w_burst & ((w_wr_en & (w_beat_inc >= {1'b0, w_limit})) | ~w_sel_valid);
    assign w_ptr_next  = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_burst) begin
            req_ready[r_grant_id] = ~fifo_full;
        end
    end

    assign fifo_wr_en   = w_wr_en;
    assign fifo_wr_data = w_wr_en ? req_data[32'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_valid  = w_burst;
    assign grant_id     = r_grant_id;
    assign beat_cnt     = r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_BURST;
                    end
                end
                default: begin
                    if (w_wr_en) begin
                        r_beat_cnt <= w_beat_inc[BEAT_W-1:0];
                    end
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_ptr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer queues drive valid/ready,
// and every fifo write is checked against an ordered expected-write scoreboard.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int IW = arb_clog2(NR);

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wr_data;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;
    logic [7:0]       beat_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .grant_valid      (grant_valid),
        .grant_id         (grant_id),
        .beat_cnt         (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [NR-1:0] mask;
        logic          af;
        int            exp_id;
    } vec_t;

    wr_t           exp_q[$];
    logic [DW-1:0] pq[NR][$];
    vec_t          vtab[7];
    int            n_chk;
    int            n_fail;
    int            wr_cnt;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] dval(input int p, input int k);
        return DW'((p << 12) | (k + 1));
    endfunction

    function automatic void load(input int p, input int n, input int start);
        for (int k = 0; k < n; k++) pq[p].push_back(dval(p, start + k));
    endfunction

    function automatic void expect_wr(input int p, input int k);
        wr_t e;
        e.id   = p;
        e.data = dval(p, k);
        exp_q.push_back(e);
    endfunction

    function automatic void drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]        = (pq[i].size() > 0);
            req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : '0;
        end
    endfunction

    function automatic bit all_done();
        bit d;
        d = !grant_valid && (exp_q.size() == 0);
        for (int i = 0; i < NR; i++) if (pq[i].size() != 0) d = 0;
        return d;
    endfunction

    // Accepted beats are captured just before the edge and popped after it.
    task automatic tick();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        drive();
    endtask

    task automatic monitor();
        wr_t e;
        if (rst_n && fifo_wr_en) begin
            wr_cnt++;
            chk("no_overflow", {31'b0, fifo_full}, 32'd0);
            chk("wr_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_id", 32'(grant_id), 32'(e.id));
                chk("wr_data", 32'(fifo_wr_data), 32'(e.data));
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        monitor();
        #1;
    endtask

    task automatic step();
        tick();
        half();
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        for (int i = 0; i < NR; i++) pq[i].delete();
        exp_q.delete();
        drive();
        #1;
        chk("rst_grant_valid", {31'b0, grant_valid}, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        half();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 400 && !all_done()) begin
            step();
            k++;
        end
        chk("drain_in_time", {31'b0, k < 400}, 32'd1);
    endtask

    task automatic run_until_beat(input int target);
        int k;
        k = 0;
        while (k < 50) begin
            tick();
            if (32'(beat_cnt) == target) break;
            half();
            k++;
        end
        chk("reach_beat", 32'(beat_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        int k;
        n_chk  = 0;
        n_fail = 0;
        wr_cnt = 0;
        rst_n  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;

        vtab[0] = '{4'b0001, 1'b0, 0};
        vtab[1] = '{4'b0100, 1'b0, 2};
        vtab[2] = '{4'b1000, 1'b1, 3};
        vtab[3] = '{4'b0110, 1'b0, 1};
        vtab[4] = '{4'b1010, 1'b1, 1};
        vtab[5] = '{4'b1111, 1'b0, 0};
        vtab[6] = '{4'b1100, 1'b1, 2};

        #2;
        // First-pick table after reset (rr_ptr=0); one beat per requester.
        foreach (vtab[t]) begin
            apply_reset();
            fifo_almost_full = vtab[t].af;
            for (int p = 0; p < NR; p++) begin
                if (vtab[t].mask[p]) begin
                    load(p, 1, 0);
                    expect_wr(p, 0);
                end
            end
            drive();
            #1;
            chk("tab_idle_no_grant", {31'b0, grant_valid}, 32'd0);
            chk("tab_idle_no_wr", {31'b0, fifo_wr_en}, 32'd0);
            step();
            chk("tab_grant_valid", {31'b0, grant_valid}, 32'd1);
            chk("tab_grant_id", 32'(grant_id), 32'(vtab[t].exp_id));
            drain();
        end

        // Single producer, three beats, then rr_ptr advances to 1.
        apply_reset();
        load(0, 3, 0);
        for (int i = 0; i < 3; i++) expect_wr(0, i);
        drive();
        wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_wr_en", {31'b0, fifo_wr_en}, 32'd1);
            chk("t1_gid", 32'(grant_id), 32'd0);
        end
        chk("t1_writes", 32'(wr_cnt), 32'd3);
        step();
        chk("t1_no_wr_after", {31'b0, fifo_wr_en}, 32'd0);
        step();
        chk("t1_released", {31'b0, grant_valid}, 32'd0);
        load(0, 1, 10);
        load(1, 1, 0);
        expect_wr(1, 0);
        expect_wr(0, 10);
        drive();
        step();
        chk("t1_rr_next", 32'(grant_id), 32'd1);
        drain();

        // All producers busy: 8-beat bursts with one bubble, order 0,1,2,3,0.
        apply_reset();
        for (int p = 0; p < NR; p++) begin
            load(p, 8, 0);
            for (int i = 0; i < 8; i++) expect_wr(p, i);
        end
        load(0, 8, 8);
        for (int i = 8; i < 16; i++) expect_wr(0, i);
        drive();
        wr_cnt = 0;
        for (int s = 1; s <= 35; s++) begin
            step();
            if (s == 9 || s == 18 || s == 27) chk("t2_bubble", {31'b0, grant_valid}, 32'd0);
            if (s == 34) chk("t2_writes_34", 32'(wr_cnt), 32'd31);
            if (s == 35) chk("t2_writes_35", 32'(wr_cnt), 32'd32);
        end
        drain();

        // almost_full held: one beat per grant, rotating through everyone.
        apply_reset();
        fifo_almost_full = 1'b1;
        for (int p = 0; p < NR; p++) load(p, 2, 0);
        for (int i = 0; i < 2; i++) for (int p = 0; p < NR; p++) expect_wr(p, i);
        drive();
        k = 0;
        while (k < 100 && !all_done()) begin
            step();
            chk("t3_beat_le1", {31'b0, beat_cnt <= 8'd1}, 32'd1);
            k++;
        end
        chk("t3_in_time", {31'b0, k < 100}, 32'd1);

        // fifo_full for 5 cycles in the middle of producer 1's burst.
        apply_reset();
        load(1, 10, 0);
        for (int i = 0; i < 10; i++) expect_wr(1, i);
        drive();
        wr_cnt = 0;
        run_until_beat(3);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            half();
            chk("t4_full_no_wr", {31'b0, fifo_wr_en}, 32'd0);
            chk("t4_full_ready", 32'(req_ready), 32'd0);
            chk("t4_full_gid", 32'(grant_id), 32'd1);
            chk("t4_full_beat", 32'(beat_cnt), 32'd3);
            chk("t4_full_gv", {31'b0, grant_valid}, 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        half();
        chk("t4_resume_wr", {31'b0, fifo_wr_en}, 32'd1);
        chk("t4_resume_data", 32'(fifo_wr_data), 32'(dval(1, 3)));
        k = 0;
        while (k < 50 && grant_valid) begin
            step();
            k++;
        end
        chk("t4_burst_len", 32'(wr_cnt), 32'd8);
        drain();

        // Asynchronous reset in the middle of producer 2's burst.
        apply_reset();
        load(2, 10, 0);
        for (int i = 0; i < 10; i++) expect_wr(2, i);
        drive();
        run_until_beat(4);
        chk("t5_gid_before", 32'(grant_id), 32'd2);
        apply_reset();
        for (int p = 0; p < NR; p++) begin
            load(p, 1, 0);
            expect_wr(p, 0);
        end
        drive();
        step();
        chk("t5_first_gid", 32'(grant_id), 32'd0);
        drain();

        // Wrap scan from rr_ptr=3 back to producer 2; pointer returns to 3.
        apply_reset();
        load(2, 1, 0);
        expect_wr(2, 0);
        drive();
        drain();
        load(2, 1, 1);
        expect_wr(2, 1);
        drive();
        step();
        chk("t6_wrap_gid", 32'(grant_id), 32'd2);
        drain();
        load(0, 1, 5);
        load(3, 1, 0);
        expect_wr(3, 0);
        expect_wr(0, 5);
        drive();
        step();
        chk("t6_ptr_after", 32'(grant_id), 32'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
